// File: rtl/keystate_pkg.sv
// Shared defaults and FSM encoding for the key/state frame checker.
package keystate_pkg;

    localparam int          KS_WORD_W    = 64;
    localparam int          KS_NWORDS    = 16;
    localparam logic [63:0] KS_TAG_CONST = 64'h5555555555555555;

    typedef enum logic {
        S_RECV = 1'b0,
        S_OUT  = 1'b1
    } state_t;

endpackage

// File: rtl/keystate_fold.sv
// XOR fold of incoming state words plus a running word count; clear wins over enable.
module keystate_fold #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_acc,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [WORD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_word;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc = r_acc;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/keystate_check.sv
// Receives NWORDS state words plus a tag word, recovers the state and checks the XOR tag.
// Optional error counter enabled by defining KEYSTATE_CHECK_ERRCNT_EN.
module keystate_check
    import keystate_pkg::*;
#(
    parameter int                WORD_W    = KS_WORD_W,
    parameter int                NWORDS    = KS_NWORDS,
    parameter logic [WORD_W-1:0] TAG_CONST = WORD_W'(KS_TAG_CONST)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_word,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NWORDS*WORD_W-1:0] out_state,
    output logic                     out_match,
    output logic                     frame_err,
    output logic [15:0]              err_cnt
);

    localparam int                CNT_W   = $clog2(NWORDS + 1);
    localparam int                SW      = NWORDS * WORD_W;
    localparam logic [CNT_W-1:0]  TAG_IDX = CNT_W'(NWORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_state_buf;
    logic [SW-1:0]     w_buf_shift;
    logic              r_match;
    logic              r_frame_err;
    logic [WORD_W-1:0] w_acc;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_is_tag;
    logic              w_tag_xfer;
    logic              w_abort;
    logic              w_shift;
    logic              w_match;
    logic              w_fold_clr;

    assign in_ready   = (r_state == S_RECV);
    assign out_valid  = (r_state == S_OUT);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_is_tag   = (w_cnt == TAG_IDX);
    assign w_tag_xfer = w_in_xfer && w_is_tag;
    assign w_abort    = w_in_xfer && !w_is_tag && in_last;
    assign w_shift    = w_in_xfer && !w_is_tag && !in_last;
    assign w_match    = (in_word == (w_acc ^ TAG_CONST)) && in_last;
    assign w_fold_clr = w_abort || w_out_xfer;

    // Word 0 enters first and ends up in the MSBs after NWORDS shifts.
    assign w_buf_shift = (r_state_buf << WORD_W) | SW'(in_word);

    keystate_fold #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_fold (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_fold_clr),
        .i_en   (w_shift),
        .i_word (in_word),
        .o_acc  (w_acc),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RECV;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RECV:  if (w_tag_xfer) w_state_nxt = S_OUT;
            S_OUT:   if (out_ready)  w_state_nxt = S_RECV;
            default: w_state_nxt = S_RECV;
        endcase
    end

    // A tag without in_last still delivers the frame, but flagged and unmatched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_buf <= '0;
            r_match     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_abort || (w_tag_xfer && !in_last);
            if (w_shift)    r_state_buf <= w_buf_shift;
            if (w_tag_xfer) r_match     <= w_match;
        end
    end

    assign out_state = r_state_buf;
    assign out_match = r_match;
    assign frame_err = r_frame_err;

`ifdef KEYSTATE_CHECK_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_evt;

    assign w_err_evt = w_abort || (w_tag_xfer && !w_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 r_err_cnt <= '0;
        else if (w_err_evt && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_keystate_check.sv
// Self-checking bench for keystate_check: directed vector table, reset/hold sequences, random frames.
module tb_keystate_check;

    localparam int          W   = 64;
    localparam int          N   = 16;
    localparam int          SW  = N * W;
    localparam logic [63:0] TAG = 64'h5555555555555555;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_word = '0;
    logic          in_ready, out_valid, out_match, frame_err;
    logic [SW-1:0] out_state;
    logic [15:0]   err_cnt;

    int checks = 0;
    int failures = 0;

    keystate_check #(.WORD_W(W), .NWORDS(N), .TAG_CONST(TAG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .out_match(out_match),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference: words of the current frame kept in a queue, outcome decided at the tag.
    logic [W-1:0]  mq[$];
    int            m_err = 0;
    bit            m_out = 0;
    logic [SW-1:0] m_state = '0;
    bit            m_match = 0;

    function automatic logic [15:0] exp_err();
`ifdef KEYSTATE_CHECK_ERRCNT_EN
        return (m_err > 65535) ? 16'hFFFF : 16'(m_err);
`else
        return 16'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < N; i++)
                if (act[SW-1-i*W -: W] !== exp[SW-1-i*W -: W]) begin
                    $display("FAIL %s word%0d actual=%0h required=%0h", nm, i,
                             act[SW-1-i*W -: W], exp[SW-1-i*W -: W]);
                    break;
                end
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting on DUT", nm);
    endtask

    task automatic model_accept(input logic [W-1:0] w, input bit last, output bit ferr);
        logic [W-1:0] x;
        ferr = 0;
        if (mq.size() < N) begin
            if (last) begin
                mq.delete();
                ferr = 1;
                m_err++;
            end else begin
                mq.push_back(w);
            end
        end else begin
            x = '0;
            m_state = '0;
            foreach (mq[i]) begin
                x ^= mq[i];
                m_state = (m_state << W) | SW'(mq[i]);
            end
            m_match = (w == (x ^ TAG)) && last;
            ferr = !last;
            if (!m_match) m_err++;
            mq.delete();
            m_out = 1;
        end
    endtask

    task automatic put(input logic [W-1:0] w, input bit last);
        bit ferr;
        int g;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            timeout("in_ready");
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_accept(w, last, ferr);
        chk("frame_err", frame_err, W'(ferr));
        if (m_out) chk("out_valid_latency", out_valid, 1);
    endtask

    task automatic gap_rand();
        int g = 0;
        while ($urandom_range(0, 1) == 1 && g < 8) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic get_out(input int hold, input bit poke);
        logic [SW-1:0] st;
        int g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!out_valid) begin
            timeout("out_valid");
            return;
        end
        chk_state("out_state", out_state, m_state);
        chk("out_match", out_match, W'(m_match));
        st = out_state;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_word  = {$urandom, $urandom};
                in_last  = 1'b1;
            end
            @(negedge clk);
            chk("in_ready_hold", in_ready, 0);
            chk("out_valid_hold", out_valid, 1);
            chk_state("out_state_stable", out_state, st);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        m_out     = 0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("err_cnt", err_cnt, W'(exp_err()));
    endtask

    typedef struct {
        int abort_at;
        bit flip;
        bit tag_last;
        int hold;
        bit exp_match;
        bit exp_tag_ferr;
    } vec_t;

    vec_t vt[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w, x, tag;
        bit           last;
        int           ab;
        int           r;

        vt[0] = '{-1, 0, 1, 0,  1, 0};
        vt[1] = '{-1, 1, 1, 0,  0, 0};
        vt[2] = '{ 5, 0, 1, 0,  1, 0};
        vt[3] = '{-1, 0, 0, 0,  0, 1};
        vt[4] = '{-1, 0, 1, 10, 1, 0};
        vt[5] = '{ 0, 1, 1, 2,  0, 0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk_state("rst_out_state", out_state, '0);
        chk("rst_out_match", out_match, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: frame words 1..16, whose XOR is 0x10.
        for (int v = 0; v < 6; v++) begin
            if (vt[v].abort_at >= 0) begin
                for (int i = 0; i <= vt[v].abort_at; i++)
                    put(W'(i + 1), i == vt[v].abort_at);
                @(negedge clk);
                chk("frame_err_pulse", frame_err, 0);
            end
            for (int i = 0; i < N; i++) put(W'(i + 1), 1'b0);
            put(64'h5555555555555545 ^ W'(vt[v].flip), vt[v].tag_last);
            chk("tbl_tag_ferr", frame_err, W'(vt[v].exp_tag_ferr));
            chk("tbl_match", out_match, W'(vt[v].exp_match));
            chk("tbl_word0", out_state[SW-1 -: W], 64'h1);
            get_out(vt[v].hold, vt[v].hold > 0);
        end

        // Reset after word 8 discards the partial frame and the error count.
        for (int i = 0; i < 9; i++) put(W'(i + 100), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk_state("mid_rst_state", out_state, '0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_match", out_match, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_err = 0;
        m_out = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) put(W'(i + 1), 1'b0);
        put(64'h5555555555555545, 1'b1);
        chk("post_rst_match", out_match, 1);
        get_out(0, 0);
        chk("post_rst_err_cnt", err_cnt, 0);

        // Random frames with input gaps, occasional aborts, bad tags and missing last.
        for (int f = 0; f < 100; f++) begin
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            x = '0;
            for (int i = 0; i < N; i++) begin
                w = {$urandom, $urandom};
                x ^= w;
                gap_rand();
                put(w, i == ab);
                if (i == ab) break;
            end
            if (ab >= 0) continue;
            tag = x ^ TAG;
            r = $urandom_range(0, 9);
            if (r == 0) tag[$urandom_range(0, W - 1)] ^= 1'b1;
            last = (r != 1);
            gap_rand();
            put(tag, last);
            get_out($urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
